mul_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the single-precision multiplier. Accepts raw IEEE-754 operand pairs from two clients, drives the shared operand parser + multiplier pair with a correctly timed start pulse, waits for completion or timeout, and returns the product and exception flags tagged with the requester ID. Sits between client issue logic and the `operands`/`multiplier` datapath.

---
 rtl/mul_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mul_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for the shared single-precision multiplier.
// Sequences IDLE -> SETUP -> START -> WAIT -> RESP and returns a tagged, registered response.
module mul_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req0_valid_i,
   input  logic [31:0] req0_x_i,
   input  logic [31:0] req0_y_i,
   output logic        req0_ready_o,
   input  logic        req1_valid_i,
   input  logic [31:0] req1_x_i,
   input  logic [31:0] req1_y_i,
   output logic        req1_ready_o,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic        rsp_id_o,
   output logic [31:0] rsp_z_o,
   output logic        rsp_invalid_o,
   output logic        rsp_overflow_o,
   output logic        rsp_timeout_o,
   output logic [31:0] mul_x_o,
   output logic [31:0] mul_y_o,
   output logic        mul_start_o,
   input  logic        mul_done_i,
   input  logic [31:0] mul_z_i,
   input  logic        mul_invalid_i,
   input  logic        mul_overflow_i
);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_START, S_WAIT, S_RESP} state_t;

   localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        id_q, id_d;
   logic [31:0] x_q, x_d;
   logic [31:0] y_q, y_d;
   logic        start_q, start_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_id_q, rsp_id_d;
   logic [31:0] rsp_z_q, rsp_z_d;
   logic        rsp_inv_q, rsp_inv_d;
   logic        rsp_ovf_q, rsp_ovf_d;
   logic        rsp_to_q, rsp_to_d;

   logic        grant_id;
   logic        accept;

   // On a tie the requester that did not win last time gets the grant.
   always_comb begin
      grant_id = 1'b0;
      if (req0_valid_i && req1_valid_i) begin
         grant_id = ~last_grant_q;
      end else if (req1_valid_i) begin
         grant_id = 1'b1;
      end
      accept = (state_q == S_IDLE) && (req0_valid_i || req1_valid_i);
   end

   assign req0_ready_o = accept && !grant_id;
   assign req1_ready_o = accept && grant_id;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      x_d          = x_q;
      y_d          = y_q;
      start_d      = 1'b0;
      cnt_d        = cnt_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_z_d      = rsp_z_q;
      rsp_inv_d    = rsp_inv_q;
      rsp_ovf_d    = rsp_ovf_q;
      rsp_to_d     = rsp_to_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               x_d     = grant_id ? req1_x_i : req0_x_i;
               y_d     = grant_id ? req1_y_i : req0_y_i;
               id_d    = grant_id;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            start_d = 1'b1;
            state_d = S_START;
         end
         S_START: begin
            cnt_d   = 8'd0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Completion takes priority over a timeout landing in the same cycle.
            if (mul_done_i) begin
               rsp_z_d     = mul_z_i;
               rsp_inv_d   = mul_invalid_i;
               rsp_ovf_d   = mul_overflow_i;
               rsp_to_d    = 1'b0;
               rsp_id_d    = id_q;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else if (cnt_q >= CNT_LIMIT) begin
               rsp_z_d     = 32'h7fffffff;
               rsp_inv_d   = 1'b1;
               rsp_ovf_d   = 1'b0;
               rsp_to_d    = 1'b1;
               rsp_id_d    = id_q;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else if (cnt_q != 8'hff) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d  = 1'b0;
               last_grant_d = rsp_id_q;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         x_q          <= 32'd0;
         y_q          <= 32'd0;
         start_q      <= 1'b0;
         cnt_q        <= 8'd0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_z_q      <= 32'd0;
         rsp_inv_q    <= 1'b0;
         rsp_ovf_q    <= 1'b0;
         rsp_to_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         x_q          <= x_d;
         y_q          <= y_d;
         start_q      <= start_d;
         cnt_q        <= cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_z_q      <= rsp_z_d;
         rsp_inv_q    <= rsp_inv_d;
         rsp_ovf_q    <= rsp_ovf_d;
         rsp_to_q     <= rsp_to_d;
      end
   end

   assign mul_x_o        = x_q;
   assign mul_y_o        = y_q;
   assign mul_start_o    = start_q;
   assign rsp_valid_o    = rsp_valid_q;
   assign rsp_id_o       = rsp_id_q;
   assign rsp_z_o        = rsp_z_q;
   assign rsp_invalid_o  = rsp_inv_q;
   assign rsp_overflow_o = rsp_ovf_q;
   assign rsp_timeout_o  = rsp_to_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a table-driven multiplier stand-in.
// Each scenario task drives its own stimulus and checks results inline.
module tb_mul_arbiter;

   localparam int TO = 8;
   localparam int MODEL_LAT = 2;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req0_valid_i, req1_valid_i;
   logic [31:0] req0_x_i, req0_y_i, req1_x_i, req1_y_i;
   logic        req0_ready_o, req1_ready_o;
   logic        rsp_valid_o, rsp_ready_i, rsp_id_o;
   logic [31:0] rsp_z_o;
   logic        rsp_invalid_o, rsp_overflow_o, rsp_timeout_o;
   logic [31:0] mul_x_o, mul_y_o;
   logic        mul_start_o, mul_done_i;
   logic [31:0] mul_z_i;
   logic        mul_invalid_i, mul_overflow_i;

   logic        model_done, stale_done, withhold;

   int tests_run = 0;
   int tests_failed = 0;

   assign mul_done_i = model_done | stale_done;

   always #5 clk = ~clk;

   mul_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req0_valid_i(req0_valid_i), .req0_x_i(req0_x_i), .req0_y_i(req0_y_i), .req0_ready_o(req0_ready_o),
      .req1_valid_i(req1_valid_i), .req1_x_i(req1_x_i), .req1_y_i(req1_y_i), .req1_ready_o(req1_ready_o),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o), .rsp_z_o(rsp_z_o),
      .rsp_invalid_o(rsp_invalid_o), .rsp_overflow_o(rsp_overflow_o), .rsp_timeout_o(rsp_timeout_o),
      .mul_x_o(mul_x_o), .mul_y_o(mul_y_o), .mul_start_o(mul_start_o), .mul_done_i(mul_done_i),
      .mul_z_i(mul_z_i), .mul_invalid_i(mul_invalid_i), .mul_overflow_i(mul_overflow_i)
   );

   function automatic void lookup(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] z, output logic inv, output logic ovf);
      logic [63:0] key;
      key = {a, b};
      inv = 1'b0;
      ovf = 1'b0;
      case (key)
         64'h3fc00000_4500001a: z = 32'h45400027;
         64'hc5fce001_34d98e63: z = 32'hbb56e686;
         64'h3f000000_bee00000: z = 32'hbe600000;
         64'h7f800000_00000000: begin z = 32'h7fffffff; inv = 1'b1; end
         64'h7f61b1e6_7e348e52: begin z = 32'h7f800000; ovf = 1'b1; end
         64'h4479ff5c_3c23d70a: z = 32'h411fff96;
         default:               z = 32'h00000000;
      endcase
   endfunction

   // Multiplier stand-in: answers MODEL_LAT cycles after the start pulse.
   initial begin
      logic [31:0] mz;
      logic        mi, mo;
      model_done = 1'b0;
      mul_z_i = 32'd0;
      mul_invalid_i = 1'b0;
      mul_overflow_i = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (mul_start_o && !withhold) begin
            lookup(mul_x_o, mul_y_o, mz, mi, mo);
            repeat (MODEL_LAT) @(posedge clk);
            #1;
            model_done = 1'b1;
            mul_z_i = mz;
            mul_invalid_i = mi;
            mul_overflow_i = mo;
            @(posedge clk); #1;
            model_done = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic wait_rsp(input int limit, output bit seen, output int n);
      n = 0;
      while (!rsp_valid_o && n < limit) begin
         tick();
         n++;
      end
      seen = rsp_valid_o;
   endtask

   task automatic issue(input bit id, input logic [31:0] x, input logic [31:0] y, output bit ok);
      int i;
      i = 0;
      if (id) begin req1_x_i = x; req1_y_i = y; req1_valid_i = 1'b1; end
      else    begin req0_x_i = x; req0_y_i = y; req0_valid_i = 1'b1; end
      #1;
      while (!(id ? req1_ready_o : req0_ready_o) && i < 50) begin
         tick();
         i++;
      end
      ok = id ? req1_ready_o : req0_ready_o;
      @(posedge clk); #1;
      if (id) req1_valid_i = 1'b0;
      else    req0_valid_i = 1'b0;
   endtask

   task automatic handshake;
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
   endtask

   task automatic test_reset;
      rst_i = 1'b1;
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      req0_x_i = 32'd0; req0_y_i = 32'd0; req1_x_i = 32'd0; req1_y_i = 32'd0;
      rsp_ready_i = 1'b0; stale_done = 1'b0; withhold = 1'b0;
      tick(); tick();
      tests_run++;
      if ({req0_ready_o, req1_ready_o, mul_start_o, rsp_valid_o} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %b required 0000", {req0_ready_o, req1_ready_o, mul_start_o, rsp_valid_o});
      end
      tests_run++;
      if ({mul_x_o, mul_y_o} !== 64'd0) begin
         tests_failed++;
         $display("FAIL reset_operands: got %h required 0", {mul_x_o, mul_y_o});
      end
      tests_run++;
      if ({rsp_id_o, rsp_z_o, rsp_invalid_o, rsp_overflow_o, rsp_timeout_o} !== 36'd0) begin
         tests_failed++;
         $display("FAIL reset_rsp: got %h required 0", {rsp_id_o, rsp_z_o, rsp_invalid_o, rsp_overflow_o, rsp_timeout_o});
      end
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_single;
      bit seen;
      int n;
      req0_x_i = 32'h3fc00000; req0_y_i = 32'h4500001a; req0_valid_i = 1'b1;
      #1;
      tests_run++;
      if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
         tests_failed++;
         $display("FAIL single_ready: got %b required 10", {req0_ready_o, req1_ready_o});
      end
      @(posedge clk); #1;
      req0_valid_i = 1'b0;
      tests_run++;
      if ({mul_x_o, mul_y_o, mul_start_o} !== {32'h3fc00000, 32'h4500001a, 1'b0}) begin
         tests_failed++;
         $display("FAIL single_setup: got %h %h start=%b required 3fc00000 4500001a start=0", mul_x_o, mul_y_o, mul_start_o);
      end
      tick();
      tests_run++;
      if (mul_start_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_start_pulse: got %b required 1", mul_start_o);
      end
      tick();
      tests_run++;
      if (mul_start_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_start_width: got %b required 0", mul_start_o);
      end
      wait_rsp(30, seen, n);
      tests_run++;
      if (!seen || n != 2) begin
         tests_failed++;
         $display("FAIL single_latency: got seen=%0d cycles=%0d required seen=1 cycles=2", seen, n);
      end
      tests_run++;
      if ({rsp_id_o, rsp_z_o, rsp_invalid_o, rsp_overflow_o, rsp_timeout_o} !== {1'b0, 32'h45400027, 3'b000}) begin
         tests_failed++;
         $display("FAIL single_rsp: got id=%b z=%h flags=%b required id=0 z=45400027 flags=000",
                  rsp_id_o, rsp_z_o, {rsp_invalid_o, rsp_overflow_o, rsp_timeout_o});
      end
      handshake();
      tests_run++;
      if (rsp_valid_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_rsp_drop: got %b required 0", rsp_valid_o);
      end
   endtask

   task automatic test_fairness;
      bit seen;
      int n;
      logic        exp_id;
      logic [31:0] exp_z;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      req0_x_i = 32'hc5fce001; req0_y_i = 32'h34d98e63;
      req1_x_i = 32'h3f000000; req1_y_i = 32'hbee00000;
      req0_valid_i = 1'b1; req1_valid_i = 1'b1;
      #1;
      tests_run++;
      if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
         tests_failed++;
         $display("FAIL tie_first_grant: got %b required 10", {req0_ready_o, req1_ready_o});
      end
      rsp_ready_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         exp_id = k[0];
         exp_z = exp_id ? 32'hbe600000 : 32'hbb56e686;
         wait_rsp(30, seen, n);
         tests_run++;
         if (!seen || rsp_id_o !== exp_id || rsp_z_o !== exp_z) begin
            tests_failed++;
            $display("FAIL tie_order[%0d]: got seen=%0d id=%b z=%h required id=%b z=%h", k, seen, rsp_id_o, rsp_z_o, exp_id, exp_z);
         end
         tick();
      end
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      rsp_ready_i = 1'b0;
      tick();
   endtask

   task automatic test_exceptions;
      bit ok, seen;
      int n;
      issue(1'b1, 32'h7f800000, 32'h00000000, ok);
      wait_rsp(30, seen, n);
      tests_run++;
      if (!ok || !seen || {rsp_id_o, rsp_z_o, rsp_invalid_o, rsp_overflow_o, rsp_timeout_o} !== {1'b1, 32'h7fffffff, 3'b100}) begin
         tests_failed++;
         $display("FAIL exc_invalid: got ok=%0d id=%b z=%h flags=%b required id=1 z=7fffffff flags=100",
                  ok, rsp_id_o, rsp_z_o, {rsp_invalid_o, rsp_overflow_o, rsp_timeout_o});
      end
      handshake();
      issue(1'b0, 32'h7f61b1e6, 32'h7e348e52, ok);
      wait_rsp(30, seen, n);
      tests_run++;
      if (!ok || !seen || {rsp_id_o, rsp_z_o, rsp_invalid_o, rsp_overflow_o, rsp_timeout_o} !== {1'b0, 32'h7f800000, 3'b010}) begin
         tests_failed++;
         $display("FAIL exc_overflow: got ok=%0d id=%b z=%h flags=%b required id=0 z=7f800000 flags=010",
                  ok, rsp_id_o, rsp_z_o, {rsp_invalid_o, rsp_overflow_o, rsp_timeout_o});
      end
      handshake();
   endtask

   task automatic test_timeout;
      bit seen, bad;
      int n;
      withhold = 1'b1;
      req0_x_i = 32'h3fc00000; req0_y_i = 32'h4500001a; req0_valid_i = 1'b1;
      #1;
      @(posedge clk); #1;
      req0_valid_i = 1'b0;
      tick();
      tests_run++;
      if (mul_start_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL timeout_start: got %b required 1", mul_start_o);
      end
      wait_rsp(TO + 20, seen, n);
      tests_run++;
      if (!seen || n != TO + 1) begin
         tests_failed++;
         $display("FAIL timeout_latency: got seen=%0d cycles=%0d required seen=1 cycles=%0d", seen, n, TO + 1);
      end
      tests_run++;
      if ({rsp_id_o, rsp_z_o, rsp_invalid_o, rsp_overflow_o, rsp_timeout_o} !== {1'b0, 32'h7fffffff, 3'b101}) begin
         tests_failed++;
         $display("FAIL timeout_rsp: got id=%b z=%h flags=%b required id=0 z=7fffffff flags=101",
                  rsp_id_o, rsp_z_o, {rsp_invalid_o, rsp_overflow_o, rsp_timeout_o});
      end
      handshake();
      withhold = 1'b0;
      tick();
      mul_z_i = 32'h12345678;
      stale_done = 1'b1;
      tick();
      stale_done = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid_o !== 1'b0 || rsp_z_o !== 32'h7fffffff) bad = 1'b1;
         tick();
      end
      tests_run++;
      if (bad) begin
         tests_failed++;
         $display("FAIL timeout_stale_done: got valid=%b z=%h required valid=0 z=7fffffff", rsp_valid_o, rsp_z_o);
      end
   endtask

   task automatic test_back_to_back;
      bit ok, seen, bad;
      int n;
      issue(1'b0, 32'h3fc00000, 32'h4500001a, ok);
      wait_rsp(30, seen, n);
      req0_x_i = 32'h4479ff5c; req0_y_i = 32'h3c23d70a; req0_valid_i = 1'b1;
      bad = !ok || !seen;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (rsp_valid_o !== 1'b1 || rsp_id_o !== 1'b0 || rsp_z_o !== 32'h45400027 ||
             {rsp_invalid_o, rsp_overflow_o, rsp_timeout_o} !== 3'b000 || req0_ready_o !== 1'b0) bad = 1'b1;
         tick();
      end
      tests_run++;
      if (bad) begin
         tests_failed++;
         $display("FAIL bp_hold: got valid=%b id=%b z=%h ready0=%b required valid=1 id=0 z=45400027 ready0=0",
                  rsp_valid_o, rsp_id_o, rsp_z_o, req0_ready_o);
      end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      tests_run++;
      if ({rsp_valid_o, req0_ready_o} !== 2'b01) begin
         tests_failed++;
         $display("FAIL bp_next_accept: got valid=%b ready0=%b required valid=0 ready0=1", rsp_valid_o, req0_ready_o);
      end
      @(posedge clk); #1;
      req0_valid_i = 1'b0;
      tests_run++;
      if ({mul_x_o, mul_y_o} !== {32'h4479ff5c, 32'h3c23d70a}) begin
         tests_failed++;
         $display("FAIL bp_capture: got %h %h required 4479ff5c 3c23d70a", mul_x_o, mul_y_o);
      end
      wait_rsp(30, seen, n);
      tests_run++;
      if (!seen || rsp_z_o !== 32'h411fff96) begin
         tests_failed++;
         $display("FAIL bp_second_rsp: got seen=%0d z=%h required z=411fff96", seen, rsp_z_o);
      end
      handshake();
   endtask

   task automatic test_reset_wait;
      bit ok, seen, bad;
      int n;
      withhold = 1'b1;
      issue(1'b1, 32'h3f000000, 32'hbee00000, ok);
      tick(); tick(); tick();
      rst_i = 1'b1;
      tick();
      tests_run++;
      if ({rsp_valid_o, mul_start_o, req0_ready_o, req1_ready_o, mul_x_o, mul_y_o, rsp_z_o, rsp_id_o} !== 101'd0) begin
         tests_failed++;
         $display("FAIL rstwait_outputs: got valid=%b start=%b x=%h y=%h z=%h required all 0",
                  rsp_valid_o, mul_start_o, mul_x_o, mul_y_o, rsp_z_o);
      end
      rst_i = 1'b0;
      withhold = 1'b0;
      bad = !ok;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid_o !== 1'b0) bad = 1'b1;
         tick();
      end
      tests_run++;
      if (bad) begin
         tests_failed++;
         $display("FAIL rstwait_no_rsp: got valid=%b ok=%0d required valid=0 ok=1", rsp_valid_o, ok);
      end
      issue(1'b0, 32'h4479ff5c, 32'h3c23d70a, ok);
      wait_rsp(30, seen, n);
      tests_run++;
      if (!ok || !seen || {rsp_id_o, rsp_z_o, rsp_invalid_o, rsp_overflow_o, rsp_timeout_o} !== {1'b0, 32'h411fff96, 3'b000}) begin
         tests_failed++;
         $display("FAIL rstwait_recover: got ok=%0d id=%b z=%h flags=%b required id=0 z=411fff96 flags=000",
                  ok, rsp_id_o, rsp_z_o, {rsp_invalid_o, rsp_overflow_o, rsp_timeout_o});
      end
      handshake();
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_exceptions();
      test_timeout();
      test_back_to_back();
      test_reset_wait();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
